axis_maxpool_2x2_engine: RTL

//  Sits directly downstream of the LReLU engine's output register slice. Consumes its requantized

---
 rtl/axis_maxpool_2x2_engine.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/axis_maxpool_2x2_engine.sv
// AXI-Stream 2x2 stride-2 signed max-pool stage with per-packet pass-through; tuser picks the mode.
// Optional AXIS_MAXPOOL_DEBUG_EN adds a debug_counts port with handshake and packet counters.
module axis_maxpool_2x2_engine #(
  parameter int WORD_WIDTH   = 8,
  parameter int UNITS        = 8,
  parameter int GROUPS       = 2,
  parameter int COPIES       = 2,
  parameter int TUSER_WIDTH  = 5,
  parameter int I_IS_NOT_MAX = 0,
  parameter int I_IS_MAX     = 1
) (
  input  logic                                        aclk,
  input  logic                                        aresetn,
  input  logic                                        s_axis_tvalid,
  output logic                                        s_axis_tready,
  input  logic [COPIES*GROUPS*UNITS*WORD_WIDTH-1:0]   s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0]                      s_axis_tuser,
  input  logic                                        s_axis_tlast,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic [COPIES*GROUPS*UNITS*WORD_WIDTH-1:0]   m_axis_tdata,
  output logic                                        m_axis_tlast
`ifdef AXIS_MAXPOOL_DEBUG_EN
  ,
  output logic [47:0]                                 debug_counts
`endif
);

  localparam int DW   = COPIES * GROUPS * UNITS * WORD_WIDTH;
  localparam int NCH  = COPIES * GROUPS;
  localparam int HALF = UNITS / 2;
  localparam int AW   = NCH * HALF * WORD_WIDTH;

  typedef enum logic [1:0] {P0, P1, P2, P3} phase_e;
  typedef enum logic {MODE_PASS, MODE_MAX} mode_e;

  function automatic logic [WORD_WIDTH-1:0] smax(input logic [WORD_WIDTH-1:0] a,
                                                 input logic [WORD_WIDTH-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  logic            m_valid_q, m_valid_d;
  logic [DW-1:0]   m_data_q,  m_data_d;
  logic            m_last_q,  m_last_d;
  phase_e          phase_q,   phase_d;
  logic            first_q,   first_d;
  mode_e           mode_q,    mode_d;
  logic [AW-1:0]   acc_a_q,   acc_a_d;
  logic [AW-1:0]   acc_b_q,   acc_b_d;

  logic            in_hs;
  logic            is_max;
  logic [DW-1:0]   pool_data;
  logic [AW-1:0]   acc_a_nxt, acc_b_nxt;
  logic [WORD_WIDTH-1:0] v_w, m_w;
  logic            unused_tuser;

  assign s_axis_tready = !m_valid_q || m_axis_tready;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  // The first beat of a packet is processed in the mode it selects.
  assign is_max        = first_q ? s_axis_tuser[I_IS_MAX] : (mode_q == MODE_MAX);
  assign unused_tuser  = ^{s_axis_tuser[I_IS_NOT_MAX], s_axis_tuser};

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;

  // Pooled beat candidate and accumulator updates for the current phase; low half is A, high half B.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch can be inferred.
    pool_data = '0;
    acc_a_nxt = acc_a_q;
    acc_b_nxt = acc_b_q;
    v_w       = '0;
    m_w       = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < HALF; i++) begin
        v_w = smax(s_axis_tdata[(c*UNITS + 2*i)*WORD_WIDTH +: WORD_WIDTH],
                   s_axis_tdata[(c*UNITS + 2*i + 1)*WORD_WIDTH +: WORD_WIDTH]);
        unique case (phase_q)
          P0: begin
            acc_a_nxt[(c*HALF + i)*WORD_WIDTH +: WORD_WIDTH] = v_w;
            pool_data[(c*UNITS + i)*WORD_WIDTH +: WORD_WIDTH] = v_w;
          end
          P1: begin
            m_w = smax(acc_a_q[(c*HALF + i)*WORD_WIDTH +: WORD_WIDTH], v_w);
            acc_a_nxt[(c*HALF + i)*WORD_WIDTH +: WORD_WIDTH] = m_w;
            pool_data[(c*UNITS + i)*WORD_WIDTH +: WORD_WIDTH] = m_w;
          end
          P2: begin
            acc_b_nxt[(c*HALF + i)*WORD_WIDTH +: WORD_WIDTH] = v_w;
            pool_data[(c*UNITS + i)*WORD_WIDTH +: WORD_WIDTH] =
              acc_a_q[(c*HALF + i)*WORD_WIDTH +: WORD_WIDTH];
            pool_data[(c*UNITS + HALF + i)*WORD_WIDTH +: WORD_WIDTH] = v_w;
          end
          default: begin
            pool_data[(c*UNITS + i)*WORD_WIDTH +: WORD_WIDTH] =
              acc_a_q[(c*HALF + i)*WORD_WIDTH +: WORD_WIDTH];
            pool_data[(c*UNITS + HALF + i)*WORD_WIDTH +: WORD_WIDTH] =
              smax(acc_b_q[(c*HALF + i)*WORD_WIDTH +: WORD_WIDTH], v_w);
          end
        endcase
      end
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    phase_d   = phase_q;
    first_d   = first_q;
    mode_d    = mode_q;
    acc_a_d   = acc_a_q;
    acc_b_d   = acc_b_q;

    if (m_axis_tready) m_valid_d = 1'b0;

    if (in_hs) begin
      first_d = s_axis_tlast;
      if (first_q) mode_d = s_axis_tuser[I_IS_MAX] ? MODE_MAX : MODE_PASS;
      if (!is_max) begin
        m_valid_d = 1'b1;
        m_data_d  = s_axis_tdata;
        m_last_d  = s_axis_tlast;
        phase_d   = P0;
      end else begin
        acc_a_d = acc_a_nxt;
        acc_b_d = acc_b_nxt;
        // A short column group is flushed on tlast with the missing half zeroed.
        if (s_axis_tlast || phase_q == P3) begin
          m_valid_d = 1'b1;
          m_data_d  = pool_data;
          m_last_d  = s_axis_tlast;
          phase_d   = P0;
        end else begin
          unique case (phase_q)
            P0:      phase_d = P1;
            P1:      phase_d = P2;
            default: phase_d = P3;
          endcase
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!aresetn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      phase_q   <= P0;
      first_q   <= 1'b1;
      mode_q    <= MODE_PASS;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      phase_q   <= phase_d;
      first_q   <= first_d;
      mode_q    <= mode_d;
      acc_a_q   <= acc_a_d;
      acc_b_q   <= acc_b_d;
    end
  end

`ifdef AXIS_MAXPOOL_DEBUG_EN
  logic [15:0] in_cnt_q, out_cnt_q, pkt_cnt_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      if (in_hs)                      in_cnt_q  <= in_cnt_q + 16'd1;
      if (m_valid_q && m_axis_tready) out_cnt_q <= out_cnt_q + 16'd1;
      if (in_hs && s_axis_tlast)      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign debug_counts = {pkt_cnt_q, out_cnt_q, in_cnt_q};
`endif

endmodule
